// File: rtl/syscall_pkg.sv
// rtl/syscall_pkg.sv - service codes and FSM state type for the syscall unit
package syscall_pkg;

  localparam int unsigned SYS_PRINT_INT  = 1;
  localparam int unsigned SYS_PRINT_CHAR = 11;
  localparam int unsigned SYS_EXIT       = 10;
  localparam int unsigned SYS_EXIT2      = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } syscallState_e;

endpackage

// File: rtl/syscall_fifo.sv
// rtl/syscall_fifo.sv - valid/ready print queue, wrap-bit pointers, head read combinationally
module syscall_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty    = (wrPtr == rdPtr);
  assign inReady  = !full;
  assign outValid = !empty;
  assign outData  = mem[rdPtr[AW-1:0]];
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= inData;
  end

endmodule

// File: rtl/syscall_unit.sv
// rtl/syscall_unit.sv - syscall decode, print queue and exit/halt FSM
// Optional simulation trace of prints, unknown codes and halt: SYSCALL_TRACE_EN
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_v0,
  input  logic [XLEN-1:0] req_a0,
  output logic            req_ready,
  output logic            out_valid,
  output logic            out_is_char,
  output logic [XLEN-1:0] out_data,
  input  logic            out_ready,
  output logic            halt,
  output logic [XLEN-1:0] exit_code,
  output logic            bad_code,
  output logic [15:0]     call_count
);

  syscallState_e state;
  syscallState_e stateNext;

  logic            isPrintInt;
  logic            isPrintChar;
  logic            isPrint;
  logic            isExit;
  logic            isUnknown;
  logic            accept;
  logic            fifoInReady;
  logic            fifoOutValid;
  logic [XLEN:0]   fifoInData;
  logic [XLEN:0]   fifoOutData;
  logic [XLEN-1:0] printPayload;

  assign isPrintInt  = (req_v0 == XLEN'(SYS_PRINT_INT));
  assign isPrintChar = (req_v0 == XLEN'(SYS_PRINT_CHAR));
  assign isPrint     = isPrintInt || isPrintChar;
  assign isExit      = (req_v0 == XLEN'(SYS_EXIT)) || (req_v0 == XLEN'(SYS_EXIT2));
  assign isUnknown   = !isPrint && !isExit;

  assign printPayload = isPrintChar ? {{(XLEN-8){1'b0}}, req_a0[7:0]} : req_a0;
  assign fifoInData   = {isPrintChar, printPayload};
  assign accept       = req_valid && req_ready;

  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        // Readiness only looks at the current fill level, so a same-cycle pop never frees a slot.
        req_ready = isPrint ? fifoInReady : 1'b1;
        if (req_valid && req_ready && isExit) stateNext = DRAIN;
      end
      DRAIN: begin
        if (!fifoOutValid) stateNext = HALTED;
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      exit_code  <= '0;
      bad_code   <= 1'b0;
      call_count <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        if (call_count != 16'hFFFF) call_count <= call_count + 16'd1;
        if (isUnknown) bad_code <= 1'b1;
        if (isExit) exit_code <= (req_v0 == XLEN'(SYS_EXIT)) ? '0 : req_a0;
      end
    end
  end

  assign out_valid   = fifoOutValid && (state != HALTED);
  assign out_is_char = fifoOutData[XLEN];
  assign out_data    = fifoOutData[XLEN-1:0];
  assign halt        = (state == HALTED);

  syscall_fifo #(
    .WIDTH(XLEN + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (accept && isPrint),
    .inReady  (fifoInReady),
    .inData   (fifoInData),
    .outValid (fifoOutValid),
    .outReady (out_ready && out_valid),
    .outData  (fifoOutData)
  );

`ifdef SYSCALL_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (out_is_char) $display("syscall: print char '%c'", out_data[7:0]);
        else             $display("syscall: print int %0d", $signed(out_data));
      end
      if (accept && isUnknown) $display("syscall: warning, unknown service code v0=%0d", req_v0);
      if (state == DRAIN && stateNext == HALTED) $display("syscall: halted, exit_code=%0d", exit_code);
    end
  end
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// tb/tb_syscall_unit.sv - directed vector table plus multi-cycle sequences for syscall_unit
module tb_syscall_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_v0;
  logic [31:0] req_a0;
  logic        req_ready;
  logic        out_valid;
  logic        out_is_char;
  logic [31:0] out_data;
  logic        out_ready;
  logic        halt;
  logic [31:0] exit_code;
  logic        bad_code;
  logic [15:0] call_count;

  int nChecks = 0;
  int nBad    = 0;

  syscall_unit #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_v0      (req_v0),
    .req_a0      (req_a0),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_is_char (out_is_char),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .halt        (halt),
    .exit_code   (exit_code),
    .bad_code    (bad_code),
    .call_count  (call_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        oready;
    logic        expReady;
    logic        expOutValid;
    logic [31:0] expData;
    logic        expIsChar;
    logic        expBad;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] c, input logic [31:0] a, input logic o);
    req_valid = v;
    req_v0    = c;
    req_a0    = a;
    out_ready = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'd1,  32'd42,        1'b1, 1'b1, 1'b1, 32'd42,        1'b0, 1'b0, 16'd1};
    vecs[1] = '{1'b1, 32'd11, 32'h141,       1'b1, 1'b1, 1'b1, 32'h41,        1'b1, 1'b0, 16'd2};
    vecs[2] = '{1'b1, 32'd99, 32'd5,         1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 16'd3};
    vecs[3] = '{1'b0, 32'd1,  32'd7,         1'b0, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 16'd3};
    vecs[4] = '{1'b1, 32'd1,  32'hFFFF_FFFB, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 16'd4};
    vecs[5] = '{1'b1, 32'd11, 32'h7A,        1'b1, 1'b1, 1'b1, 32'h7A,        1'b1, 1'b1, 16'd5};
    vecs[6] = '{1'b1, 32'd0,  32'd0,         1'b0, 1'b1, 1'b1, 32'h7A,        1'b1, 1'b1, 16'd6};
    vecs[7] = '{1'b1, 32'h101, 32'd3,        1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 16'd7};

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #2;
    chk("reset out_valid",  32'(out_valid), 32'd0);
    chk("reset halt",       32'(halt), 32'd0);
    chk("reset exit_code",  exit_code, 32'd0);
    chk("reset bad_code",   32'(bad_code), 32'd0);
    chk("reset call_count", 32'(call_count), 32'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].v0, vecs[i].a0, vecs[i].oready);
      #1;
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
      step();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expOutValid));
      if (vecs[i].expOutValid) begin
        chk($sformatf("vec%0d out_data", i), out_data, vecs[i].expData);
        chk($sformatf("vec%0d out_is_char", i), 32'(out_is_char), 32'(vecs[i].expIsChar));
      end
      chk($sformatf("vec%0d bad_code", i), 32'(bad_code), 32'(vecs[i].expBad));
      chk($sformatf("vec%0d call_count", i), 32'(call_count), 32'(vecs[i].expCnt));
      chk($sformatf("vec%0d halt", i), 32'(halt), 32'd0);
    end

    // Fill to depth, fifth print must stall with no same-cycle bypass.
    doReset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'd1, 32'(10 + k), 1'b0);
      #1;
      chk($sformatf("fill%0d req_ready", k), 32'(req_ready), 32'd1);
      step();
    end
    drive(1'b1, 32'd1, 32'd14, 1'b0);
    #1;
    chk("full req_ready", 32'(req_ready), 32'd0);
    step();
    chk("full call_count", 32'(call_count), 32'd4);
    out_ready = 1'b1;
    #1;
    chk("nobypass req_ready", 32'(req_ready), 32'd0);
    step();
    chk("after pop head", out_data, 32'd11);
    chk("after pop call_count", 32'(call_count), 32'd4);
    out_ready = 1'b0;
    #1;
    chk("freed req_ready", 32'(req_ready), 32'd1);
    step();
    chk("fifth call_count", 32'(call_count), 32'd5);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d out_data", k), out_data, 32'(11 + k));
      step();
    end
    chk("drained out_valid", 32'(out_valid), 32'd0);

    // Exit with two queued prints: drain then halt.
    doReset();
    drive(1'b1, 32'd1, 32'd100, 1'b0);
    step();
    drive(1'b1, 32'd1, 32'd101, 1'b0);
    step();
    drive(1'b1, 32'd17, 32'd3, 1'b0);
    #1;
    chk("exit req_ready", 32'(req_ready), 32'd1);
    step();
    drive(1'b1, 32'd1, 32'd5, 1'b0);
    #1;
    chk("drain req_ready", 32'(req_ready), 32'd0);
    chk("drain exit_code", exit_code, 32'd3);
    chk("drain halt", 32'(halt), 32'd0);
    drive(1'b0, 32'd1, 32'd5, 1'b1);
    chk("drain head0", out_data, 32'd100);
    step();
    chk("drain head1", out_data, 32'd101);
    step();
    chk("drain empty out_valid", 32'(out_valid), 32'd0);
    chk("drain empty halt", 32'(halt), 32'd0);
    step();
    chk("halted halt", 32'(halt), 32'd1);
    chk("halted req_ready", 32'(req_ready), 32'd0);
    chk("halted exit_code", exit_code, 32'd3);
    drive(1'b1, 32'd1, 32'd5, 1'b1);
    step();
    step();
    chk("halted terminal", 32'(halt), 32'd1);
    chk("halted out_valid", 32'(out_valid), 32'd0);
    chk("halted call_count", 32'(call_count), 32'd3);

    // Exit code 10 ignores a0.
    doReset();
    drive(1'b1, 32'd10, 32'd55, 1'b1);
    step();
    chk("exit10 exit_code", exit_code, 32'd0);
    chk("exit10 not yet halted", 32'(halt), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    chk("exit10 halt", 32'(halt), 32'd1);

    // Asynchronous reset mid-drain clears everything before the next edge.
    doReset();
    drive(1'b1, 32'd99, 32'd0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'd1, 32'(7 + k), 1'b0);
      step();
    end
    drive(1'b1, 32'd17, 32'd9, 1'b0);
    step();
    drive(1'b0, 32'd1, 32'd0, 1'b0);
    #1;
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    chk("pre-reset bad_code", 32'(bad_code), 32'd1);
    chk("pre-reset call_count", 32'(call_count), 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async halt", 32'(halt), 32'd0);
    chk("async call_count", 32'(call_count), 32'd0);
    chk("async bad_code", 32'(bad_code), 32'd0);
    chk("async exit_code", exit_code, 32'd0);
    step();
    rst_n = 1'b1;
    chk("post-reset out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'd1, 32'd77, 1'b0);
    #1;
    chk("post-reset req_ready", 32'(req_ready), 32'd1);
    step();
    chk("post-reset call_count", 32'(call_count), 32'd1);
    chk("post-reset out_data", out_data, 32'd77);
    chk("post-reset halt", 32'(halt), 32'd0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, width of v0/a0 operands and output data.
REQ-002 SHALL have parameter FIFO_DEPTH, 4, print-queue entries, power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  pipeline presents a syscall.
REQ-006 SHALL have port req_v0  input  XLEN  service code.
REQ-007 SHALL have port req_a0  input  XLEN  service argument.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle.
REQ-009 SHALL have port out_valid  output  1  queued print entry available.
REQ-010 SHALL have port out_is_char  output  1  entry is a character (else integer).
REQ-011 SHALL have port out_data  output  XLEN  print payload.
REQ-012 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-013 SHALL have port halt  output  1  execution ended, all prints drained.
REQ-014 SHALL have port exit_code  output  XLEN  program exit status.
REQ-015 SHALL have port bad_code  output  1  sticky, unknown service code seen.
REQ-016 SHALL have port call_count  output  16  accepted requests, saturating at 16'hFFFF.

Function
REQ-017 SHALL accept a request when req_valid & req_ready, capturing v0/a0 that edge.
REQ-018 SHALL decode v0: 1 print-int, 11 print-char (a0[7:0] zero-extended), 10 exit code 0, 17 exit code a0; any other value unknown.
REQ-019 SHALL implement FSM states IDLE, DRAIN, HALTED.
REQ-020 In IDLE, req_ready SHALL be combinational: !full for print codes, 1 for exit and unknown codes.
REQ-021 SHALL not bypass: when FIFO full, req_ready=0 even if a dequeue occurs the same cycle.
REQ-022 Accepted print SHALL enqueue; entry visible on out_* the cycle after acceptance (latency 1).
REQ-023 Simultaneous enqueue and dequeue when not full SHALL both occur, occupancy unchanged.
REQ-024 Accepted exit SHALL register exit_code and move IDLE->DRAIN.
REQ-025 In DRAIN and HALTED, req_ready SHALL be 0.
REQ-026 DRAIN->HALTED SHALL occur on the edge where FIFO is empty; halt asserts in HALTED only.
REQ-027 HALTED SHALL be terminal until reset; out_valid stays 0.
REQ-028 Accepted unknown code SHALL set bad_code (sticky), enqueue nothing, remain IDLE.
REQ-029 call_count SHALL increment on every accepted request, including unknown codes.
REQ-030 out_data/out_is_char SHALL be stable while out_valid & !out_ready.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH with one extra bit distinguishing full/empty.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, FIFO empty, out_valid 0, halt 0, exit_code 0, bad_code 0, call_count 0.
REQ-033 Reset mid-DRAIN SHALL discard queued entries; no halt.
REQ-034 After rst_n deasserts, first request SHALL be acceptable on the next rising edge.

Configuration
REQ-035 Macro SYSCALL_TRACE_EN defined: simulation SHALL $display each dequeued entry (decimal for int, character for char), a warning with v0 on unknown code, and a message with exit_code on entering HALTED.
REQ-036 Macro SYSCALL_TRACE_EN undefined: no display statements compiled; port behaviour identical.

Structure
REQ-037 Package syscall_pkg SHALL hold service-code constants (SYS_PRINT_INT=1, SYS_PRINT_CHAR=11, SYS_EXIT=10, SYS_EXIT2=17) and the FSM state typedef.
REQ-038 SHALL instantiate one sub-module syscall_fifo (parametrised width XLEN+1, depth FIFO_DEPTH, valid/ready both sides).

Verification
REQ-039 v0=1,a0=42, out_ready=1 -> out_valid next cycle, out_data=42, out_is_char=0, call_count=1.
REQ-040 Five print-ints, out_ready=0, depth 4 -> four accepted, fifth req_ready=0 until one dequeue, then accepted.
REQ-041 Two prints queued, then v0=17,a0=3 -> DRAIN, req_ready=0; after both drained halt=1, exit_code=3.
REQ-042 v0=11,a0=32'h141 -> out_data=32'h41, out_is_char=1.
REQ-043 v0=99 -> bad_code=1 persists, nothing enqueued, state IDLE, call_count increments.
REQ-044 rst_n low during DRAIN with 3 queued -> out_valid=0, halt=0, call_count=0 immediately, before next clk edge.
